// File: rtl/assoc_data_cache_pkg.sv
// Shared defaults and FSM encoding for the
// set-associative write-back data cache.
package assoc_data_cache_pkg;

  localparam int WORD_SIZE_D   = 32;
  localparam int BLOCK_INDEX_D = 2;
  localparam int CACHE_INDEX_D = 3;
  localparam int WAYS_D        = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    REFILL,
    FLUSH
  } state_t;

endpackage

// File: rtl/assoc_data_cache_way.sv
// One cache way: tag/valid/dirty/data arrays,
// combinational read by index, word-merge write.
module assoc_data_cache_way
  import assoc_data_cache_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_D,
  parameter int BLOCK_INDEX = BLOCK_INDEX_D,
  parameter int CACHE_INDEX = CACHE_INDEX_D,
  localparam int BS = 1 << BLOCK_INDEX,
  localparam int SETS = 1 << CACHE_INDEX,
  localparam int TW = WORD_SIZE - BLOCK_INDEX - CACHE_INDEX,
  localparam int BW = WORD_SIZE * BS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CACHE_INDEX-1:0] idx,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TW-1:0]          rd_tag,
  output logic [BW-1:0]          rd_block,
  input  logic                   fill_en,
  input  logic                   merge_en,
  input  logic                   clean_en,
  input  logic [TW-1:0]          fill_tag,
  input  logic [BW-1:0]          fill_block,
  input  logic [BLOCK_INDEX-1:0] word_off,
  input  logic [WORD_SIZE-1:0]   word_data
);

  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;
  logic [TW-1:0]   tags [SETS];
  logic [BW-1:0]   data [SETS];
  logic [BW-1:0]   merged;

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_block = data[idx];

  // Line image to write: refill or current data, optionally with one word replaced
  always_comb begin
    merged = fill_en ? fill_block : data[idx];
    for (int k = 0; k < BS; k++) begin
      if (merge_en && word_off == BLOCK_INDEX'(k))
        merged[(BS-1-k)*WORD_SIZE +: WORD_SIZE] = word_data;
    end
  end

  // Status bits: install sets valid, a merged store dirties, flush cleans
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= merge_en;
    end else if (merge_en) begin
      dirty[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty[idx] <= 1'b0;
    end
  end

  // Tag and data storage, plain memory without reset
  always_ff @(posedge clk) begin
    if (fill_en || merge_en)
      data[idx] <= merged;
    if (fill_en)
      tags[idx] <= fill_tag;
  end

endmodule

// File: rtl/assoc_data_cache.sv
// N-way write-back, write-allocate data cache
// with block memory port and explicit flush.
module assoc_data_cache
  import assoc_data_cache_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_D,
  parameter int BLOCK_INDEX = BLOCK_INDEX_D,
  parameter int CACHE_INDEX = CACHE_INDEX_D,
  parameter int WAYS        = WAYS_D,
  localparam int BS = 1 << BLOCK_INDEX,
  localparam int SETS = 1 << CACHE_INDEX,
  localparam int TW = WORD_SIZE - BLOCK_INDEX - CACHE_INDEX,
  localparam int BW = WORD_SIZE * BS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_hit,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 mem_req_valid,
  output logic                 mem_req_write,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  output logic [BW-1:0]        mem_req_wdata,
  input  logic                 mem_ack,
  input  logic [BW-1:0]        mem_rdata
);

  state_t state;

  logic                   r_write;
  logic [WORD_SIZE-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic                   vway;
  logic [SETS-1:0]        lru;
  logic [CACHE_INDEX-1:0] fset;
  logic                   fway;

  logic [BLOCK_INDEX-1:0] r_off;
  logic [CACHE_INDEX-1:0] r_idx;
  logic [TW-1:0]          r_tag;
  logic [CACHE_INDEX-1:0] idx;

  logic          rd_valid [WAYS];
  logic          rd_dirty [WAYS];
  logic [TW-1:0] rd_tag   [WAYS];
  logic [BW-1:0] rd_block [WAYS];

  logic [WAYS-1:0] fill_en;
  logic [WAYS-1:0] merge_en;
  logic [WAYS-1:0] clean_en;

  logic                 hit;
  logic                 hit_way;
  logic                 vsel;
  logic                 acked;
  logic                 fdirty;
  logic                 fstep;
  logic                 flast;
  logic [WORD_SIZE-1:0] hit_word;
  logic [WORD_SIZE-1:0] fill_word;
  logic [WORD_SIZE-1:0] blk_addr;
  logic [WORD_SIZE-1:0] vic_addr;
  logic [WORD_SIZE-1:0] fl_addr;

  assign r_off = r_addr[BLOCK_INDEX-1:0];
  assign r_idx = r_addr[BLOCK_INDEX +: CACHE_INDEX];
  assign r_tag = r_addr[WORD_SIZE-1 -: TW];
  assign idx   = (state == FLUSH) ? fset : r_idx;

  assign acked  = mem_req_valid && mem_ack;
  assign fdirty = rd_valid[fway] && rd_dirty[fway];
  assign fstep  = mem_req_valid ? mem_ack : !fdirty;
  assign flast  = (fset == CACHE_INDEX'(SETS-1))
               && (WAYS == 1 || fway);

  assign blk_addr = {r_tag, r_idx, {BLOCK_INDEX{1'b0}}};
  assign vic_addr = {rd_tag[vsel], r_idx, {BLOCK_INDEX{1'b0}}};
  assign fl_addr  = {rd_tag[fway], fset, {BLOCK_INDEX{1'b0}}};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assoc_data_cache_way #(
      .WORD_SIZE  (WORD_SIZE),
      .BLOCK_INDEX(BLOCK_INDEX),
      .CACHE_INDEX(CACHE_INDEX)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .rd_valid  (rd_valid[g]),
      .rd_dirty  (rd_dirty[g]),
      .rd_tag    (rd_tag[g]),
      .rd_block  (rd_block[g]),
      .fill_en   (fill_en[g]),
      .merge_en  (merge_en[g]),
      .clean_en  (clean_en[g]),
      .fill_tag  (r_tag),
      .fill_block(mem_rdata),
      .word_off  (r_off),
      .word_data (r_wdata)
    );
  end

  // Tag compare across ways and victim choice for a miss
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    vsel    = (WAYS == 1) ? 1'b0 : lru[r_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && rd_tag[w] == r_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w])
        vsel = 1'(w);
    end
  end

  // Requested word out of the hit line and out of the refill block
  always_comb begin
    hit_word  = '0;
    fill_word = '0;
    for (int k = 0; k < BS; k++) begin
      if (r_off == BLOCK_INDEX'(k)) begin
        hit_word  = rd_block[hit_way][(BS-1-k)*WORD_SIZE +: WORD_SIZE];
        fill_word = mem_rdata[(BS-1-k)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Per-way write strobes for install, store merge and flush clean
  always_comb begin
    fill_en  = '0;
    merge_en = '0;
    clean_en = '0;
    for (int w = 0; w < WAYS; w++) begin
      fill_en[w]  = (state == REFILL) && acked && vway == 1'(w);
      merge_en[w] = r_write && (fill_en[w]
                 || (state == LOOKUP && hit && hit_way == 1'(w)));
      clean_en[w] = (state == FLUSH) && acked && fway == 1'(w);
    end
  end

  // LRU bit names the way to evict next; touched on every hit and fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru <= '0;
    end else if (WAYS == 2) begin
      if (state == LOOKUP && hit)
        lru[r_idx] <= ~hit_way;
      else if (state == REFILL && acked)
        lru[r_idx] <= ~vway;
    end
  end

  // Main controller with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_hit       <= 1'b0;
      flush_done    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      vway          <= 1'b0;
      fset          <= '0;
      fway          <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            state     <= FLUSH;
            req_ready <= 1'b0;
            fset      <= '0;
            fway      <= 1'b0;
          end else if (req_valid) begin
            state     <= LOOKUP;
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_rdata <= r_write ? r_wdata : hit_word;
          end else begin
            vway          <= vsel;
            mem_req_valid <= 1'b1;
            if (rd_valid[vsel] && rd_dirty[vsel]) begin
              state         <= WB;
              mem_req_write <= 1'b1;
              mem_req_addr  <= vic_addr;
              mem_req_wdata <= rd_block[vsel];
            end else begin
              state         <= REFILL;
              mem_req_write <= 1'b0;
              mem_req_addr  <= blk_addr;
            end
          end
        end
        WB: begin
          if (acked) begin
            state         <= REFILL;
            mem_req_write <= 1'b0;
            mem_req_addr  <= blk_addr;
          end
        end
        REFILL: begin
          if (acked) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_hit       <= 1'b0;
            rsp_rdata     <= r_write ? r_wdata : fill_word;
          end
        end
        FLUSH: begin
          if (!mem_req_valid && fdirty) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_addr  <= fl_addr;
            mem_req_wdata <= rd_block[fway];
          end
          if (acked)
            mem_req_valid <= 1'b0;
          if (fstep) begin
            if (flast) begin
              state      <= IDLE;
              req_ready  <= 1'b1;
              flush_done <= 1'b1;
            end else if (WAYS == 1 || fway) begin
              fway <= 1'b0;
              fset <= fset + CACHE_INDEX'(1);
            end else begin
              fway <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
